// File: rtl/bist_fault_logger_if.sv
// bist_fault_logger_if
//   Bundles the BIST compare stream, the verdict outputs and the fault-log
//   read port of bist_fault_logger.
//   Macro: BIST_STOP_ON_FAIL_EN adds halt_req (logger -> controller).
//   master : BIST controller / host side (drives compare stream, test_done, log_rd)
//   slave  : bist_fault_logger
interface bist_fault_logger_if #(
  parameter int ADDR_W = 8,
  parameter int DAT_W  = 4,
  parameter int CNT_W  = 10
);
  logic              en_in;
  logic              cmp_valid;
  logic [ADDR_W-1:0] addr_in;
  logic [DAT_W-1:0]  exp_dat;
  logic [DAT_W-1:0]  read_d;
  logic              test_done;
  logic [CNT_W-1:0]  fault_cnt;
  logic              fail;
  logic              pass;
  logic              busy;
  logic              log_rd;
  logic [ADDR_W-1:0] log_addr;
  logic [DAT_W-1:0]  log_syn;
  logic              log_empty;
  logic              log_ovf;
`ifdef BIST_STOP_ON_FAIL_EN
  logic              halt_req;
`endif

  modport master (
    output en_in, cmp_valid, addr_in, exp_dat, read_d, test_done, log_rd,
    input  fault_cnt, fail, pass, busy, log_addr, log_syn, log_empty, log_ovf
`ifdef BIST_STOP_ON_FAIL_EN
    , input halt_req
`endif
  );

  modport slave (
    input  en_in, cmp_valid, addr_in, exp_dat, read_d, test_done, log_rd,
    output fault_cnt, fail, pass, busy, log_addr, log_syn, log_empty, log_ovf
`ifdef BIST_STOP_ON_FAIL_EN
    , output halt_req
`endif
  );
endinterface

// File: rtl/bist_fault_logger.sv
// bist_fault_logger
//   Checks each SRAM read word of a March C BIST run against the expected
//   word, counts mismatches (saturating), logs {address, syndrome} of each
//   fault in a first-word-fall-through FIFO and gives a pass/fail verdict.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : synchronous active-low reset
//     bus    : bist_fault_logger_if.slave (compare stream, verdict, log port)
//   Macro: BIST_STOP_ON_FAIL_EN adds bus.halt_req, set after the first fault
//   of a session.
//
//   state | meaning
//   IDLE  | no session running, waiting for en_in rise
//   RUN   | march in progress, compares active
//   DONE  | march complete, verdict valid
module bist_fault_logger #(
  parameter int ADDR_W    = 8,
  parameter int DAT_W     = 4,
  parameter int LOG_DEPTH = 8,
  parameter int CNT_W     = 10
) (
  input logic                clk,
  input logic                rst_n,
  bist_fault_logger_if.slave bus
);
  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(LOG_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_en_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_fail, r_pass, r_ovf;
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_mem_addr [LOG_DEPTH];
  logic [DAT_W-1:0]  r_mem_syn  [LOG_DEPTH];
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DAT_W-1:0]  r_hold_syn;
  logic              w_start, w_mismatch, w_push, w_pop, w_empty, w_full;
  logic [ADDR_W-1:0] w_log_addr;
  logic [DAT_W-1:0]  w_log_syn;

  // A session can only start from IDLE or DONE; in RUN en_in is already high.
  assign w_start    = bus.en_in && !r_en_d && (r_state != ST_RUN);
  assign w_mismatch = (r_state == ST_RUN) && bus.cmp_valid && (bus.exp_dat != bus.read_d);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == LP_FULL);
  assign w_pop      = bus.log_rd && !w_empty;
  // When full, a same-cycle pop frees the slot being written.
  assign w_push     = w_mismatch && (!w_full || w_pop);
  assign w_cnt_nxt  = (w_mismatch && (r_cnt != '1)) ? r_cnt + CNT_W'(1) : r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.test_done)   w_state_nxt = ST_DONE;
        else if (!bus.en_in) w_state_nxt = ST_IDLE;
      end
      ST_DONE: if (w_start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_en_d      <= 1'b0;
      r_cnt       <= '0;
      r_fail      <= 1'b0;
      r_pass      <= 1'b0;
      r_ovf       <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_hold_addr <= '0;
      r_hold_syn  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_en_d  <= bus.en_in;
      // Verdict looks at the post-increment count so a fault coincident
      // with test_done is reflected.
      r_pass  <= (w_state_nxt == ST_DONE) && (w_cnt_nxt == '0);
      if (!w_empty) begin
        r_hold_addr <= w_log_addr;
        r_hold_syn  <= w_log_syn;
      end
      if (w_start) begin
        r_cnt    <= '0;
        r_fail   <= 1'b0;
        r_ovf    <= 1'b0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
        if (w_mismatch) r_fail <= 1'b1;
        if (w_mismatch && !w_push) r_ovf <= 1'b1;
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (PTR_W+1)'(1);
          2'b01:   r_count <= r_count - (PTR_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= bus.addr_in;
      r_mem_syn[r_wr_ptr]  <= bus.exp_dat ^ bus.read_d;
    end
  end

  assign w_log_addr = w_empty ? r_hold_addr : r_mem_addr[r_rd_ptr];
  assign w_log_syn  = w_empty ? r_hold_syn  : r_mem_syn[r_rd_ptr];

`ifdef BIST_STOP_ON_FAIL_EN
  logic r_halt;
  always_ff @(posedge clk) begin
    if (!rst_n)          r_halt <= 1'b0;
    else if (w_start)    r_halt <= 1'b0;
    else if (w_mismatch) r_halt <= 1'b1;
  end
  assign bus.halt_req = r_halt;
`endif

  assign bus.fault_cnt = r_cnt;
  assign bus.fail      = r_fail;
  assign bus.pass      = r_pass;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.log_addr  = w_log_addr;
  assign bus.log_syn   = w_log_syn;
  assign bus.log_empty = w_empty;
  assign bus.log_ovf   = r_ovf;
endmodule

// File: tb/tb_bist_fault_logger.sv
// tb_bist_fault_logger
//   Directed bench for bist_fault_logger. Inputs change and outputs are
//   sampled 1 ns after each rising edge.
module tb_bist_fault_logger;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bist_fault_logger_if #(.ADDR_W(8), .DAT_W(4), .CNT_W(10)) bus ();

  bist_fault_logger #(.ADDR_W(8), .DAT_W(4), .LOG_DEPTH(8), .CNT_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input logic v, input logic [7:0] a, input logic [3:0] e, input logic [3:0] r);
    bus.cmp_valid = v;
    bus.addr_in   = a;
    bus.exp_dat   = e;
    bus.read_d    = r;
  endtask

  task automatic new_session();
    bus.en_in = 1'b0;
    tick();
    bus.en_in = 1'b1;
    tick();
  endtask

  logic [7:0] exp_heads [8];

  initial begin
    rst_n = 1'b0;
    bus.en_in = 1'b0; bus.test_done = 1'b0; bus.log_rd = 1'b0;
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    tick(); tick();
    chk("rst_cnt",   32'(bus.fault_cnt), 32'd0);
    chk("rst_fail",  32'(bus.fail),      32'd0);
    chk("rst_pass",  32'(bus.pass),      32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_ovf",   32'(bus.log_ovf),   32'd0);
    chk("rst_empty", 32'(bus.log_empty), 32'd1);
    chk("rst_laddr", 32'(bus.log_addr),  32'd0);
    chk("rst_lsyn",  32'(bus.log_syn),   32'd0);
    rst_n = 1'b1;
    tick();

    // clean run
    bus.en_in = 1'b1;
    tick();
    chk("clean_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 256; i++) begin
      cmp(1'b1, 8'(i), 4'hA, 4'hA);
      tick();
    end
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    bus.test_done = 1'b1;
    tick();
    bus.test_done = 1'b0;
    chk("clean_pass",  32'(bus.pass),      32'd1);
    chk("clean_fail",  32'(bus.fail),      32'd0);
    chk("clean_cnt",   32'(bus.fault_cnt), 32'd0);
    chk("clean_empty", 32'(bus.log_empty), 32'd1);
    chk("clean_busy0", 32'(bus.busy),      32'd0);

    // single fault
    new_session();
    cmp(1'b1, 8'h3C, 4'h5, 4'h4);
    tick();
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    chk("sf_fail",  32'(bus.fail),      32'd1);
    chk("sf_cnt",   32'(bus.fault_cnt), 32'd1);
    chk("sf_empty", 32'(bus.log_empty), 32'd0);
    chk("sf_addr",  32'(bus.log_addr),  32'h3C);
    chk("sf_syn",   32'(bus.log_syn),   32'h1);
    bus.test_done = 1'b1;
    tick();
    bus.test_done = 1'b0;
    chk("sf_pass", 32'(bus.pass), 32'd0);
    chk("sf_busy", 32'(bus.busy), 32'd0);
    bus.log_rd = 1'b1;
    tick();
    bus.log_rd = 1'b0;
    chk("sf_empty_after_rd", 32'(bus.log_empty), 32'd1);
    chk("sf_addr_hold",      32'(bus.log_addr),  32'h3C);

    // overflow and saturation
    new_session();
    chk("ovf_cleared", 32'(bus.log_ovf), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cmp(1'b1, 8'(i), 4'hF, 4'h0);
      tick();
    end
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    chk("ovf_cnt",  32'(bus.fault_cnt), 32'd12);
    chk("ovf_flag", 32'(bus.log_ovf),   32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_nonempty", 32'(bus.log_empty), 32'd0);
      chk("ovf_head",     32'(bus.log_addr),  32'(i));
      bus.log_rd = 1'b1;
      tick();
      bus.log_rd = 1'b0;
    end
    chk("ovf_drained", 32'(bus.log_empty), 32'd1);
    for (int i = 0; i < 1100; i++) begin
      cmp(1'b1, 8'(i), 4'h6, 4'h9);
      tick();
    end
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    chk("sat_cnt", 32'(bus.fault_cnt), 32'd1023);

    // test_done coincident with a fault
    new_session();
    chk("td_cnt_clr", 32'(bus.fault_cnt), 32'd0);
    cmp(1'b1, 8'hFF, 4'h3, 4'h0);
    bus.test_done = 1'b1;
    tick();
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    bus.test_done = 1'b0;
    chk("td_busy", 32'(bus.busy),      32'd0);
    chk("td_cnt",  32'(bus.fault_cnt), 32'd1);
    chk("td_pass", 32'(bus.pass),      32'd0);
    chk("td_addr", 32'(bus.log_addr),  32'hFF);
    chk("td_syn",  32'(bus.log_syn),   32'h3);

    // push + pop while full
    new_session();
    for (int i = 0; i < 8; i++) begin
      cmp(1'b1, 8'h20 + 8'(i), 4'h1, 4'h0);
      tick();
    end
    chk("full_ovf0", 32'(bus.log_ovf), 32'd0);
    cmp(1'b1, 8'h40, 4'h1, 4'h0);
    bus.log_rd = 1'b1;
    tick();
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    bus.log_rd = 1'b0;
    chk("full_pp_ovf", 32'(bus.log_ovf),   32'd0);
    chk("full_pp_cnt", 32'(bus.fault_cnt), 32'd9);
    for (int i = 0; i < 7; i++) exp_heads[i] = 8'h21 + 8'(i);
    exp_heads[7] = 8'h40;
    for (int i = 0; i < 8; i++) begin
      chk("full_pp_nonempty", 32'(bus.log_empty), 32'd0);
      chk("full_pp_head",     32'(bus.log_addr),  32'(exp_heads[i]));
      bus.log_rd = 1'b1;
      tick();
      bus.log_rd = 1'b0;
    end
    chk("full_pp_drained", 32'(bus.log_empty), 32'd1);

    // push + pop while empty
    cmp(1'b1, 8'h55, 4'h2, 4'h0);
    bus.log_rd = 1'b1;
    tick();
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    bus.log_rd = 1'b0;
    chk("empty_pp_empty", 32'(bus.log_empty), 32'd0);
    chk("empty_pp_addr",  32'(bus.log_addr),  32'h55);
    chk("empty_pp_syn",   32'(bus.log_syn),   32'h2);

    // en_in falls mid-run
    bus.en_in = 1'b0;
    tick();
    chk("abort_busy",  32'(bus.busy),      32'd0);
    chk("abort_pass",  32'(bus.pass),      32'd0);
    chk("abort_fail",  32'(bus.fail),      32'd1);
    chk("abort_empty", 32'(bus.log_empty), 32'd0);
    cmp(1'b1, 8'h77, 4'h1, 4'h2);
    tick();
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    chk("idle_ignore_cnt", 32'(bus.fault_cnt), 32'd10);

    // reset mid-run
    bus.en_in = 1'b1;
    tick();
    cmp(1'b1, 8'h12, 4'h1, 4'h0);
    tick();
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    rst_n = 1'b0;
    bus.en_in = 1'b0;
    tick();
    chk("mrst_cnt",   32'(bus.fault_cnt), 32'd0);
    chk("mrst_fail",  32'(bus.fail),      32'd0);
    chk("mrst_busy",  32'(bus.busy),      32'd0);
    chk("mrst_pass",  32'(bus.pass),      32'd0);
    chk("mrst_ovf",   32'(bus.log_ovf),   32'd0);
    chk("mrst_empty", 32'(bus.log_empty), 32'd1);
    chk("mrst_laddr", 32'(bus.log_addr),  32'd0);
    rst_n = 1'b1;
    tick();
    bus.en_in = 1'b1;
    tick();
    chk("restart_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cmp(1'b1, 8'(i), 4'h7, 4'h7);
      tick();
    end
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    bus.test_done = 1'b1;
    tick();
    bus.test_done = 1'b0;
    chk("restart_pass",  32'(bus.pass),      32'd1);
    chk("restart_cnt",   32'(bus.fault_cnt), 32'd0);
    chk("restart_empty", 32'(bus.log_empty), 32'd1);

`ifdef BIST_STOP_ON_FAIL_EN
    new_session();
    chk("halt_clr0", 32'(bus.halt_req), 32'd0);
    cmp(1'b1, 8'h10, 4'h4, 4'h0);
    tick();
    chk("halt_set", 32'(bus.halt_req), 32'd1);
    cmp(1'b1, 8'h11, 4'h4, 4'h1);
    tick();
    cmp(1'b0, 8'h00, 4'h0, 4'h0);
    tick();
    chk("halt_held", 32'(bus.halt_req),  32'd1);
    chk("halt_cnt",  32'(bus.fault_cnt), 32'd2);
    chk("halt_h0",   32'(bus.log_addr),  32'h10);
    bus.log_rd = 1'b1;
    tick();
    bus.log_rd = 1'b0;
    chk("halt_h1",   32'(bus.log_addr),  32'h11);
    chk("halt_syn1", 32'(bus.log_syn),   32'h5);
    new_session();
    chk("halt_clr", 32'(bus.halt_req), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
